// File: rtl/shared_adder_sched.sv
// Shares one external 4-bit adder between two requesters. A WIDTH-bit sum is built one
// nibble per cycle and returned on a single tagged response channel.
module shared_adder_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             resp_id,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             last_grant;
  logic             id_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             grant0, grant1;

  // Round-robin: on contention the requester that did not win last time goes first.
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;

  assign resp_valid = (state == DONE);
  assign resp_sum   = sum_reg;
  assign resp_cout  = carry_reg;
  assign resp_id    = id_reg;
  assign busy       = (state != IDLE);

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == CALC) begin
      add_a   = a_reg[{idx, 2'b00} +: 4];
      add_b   = b_reg[{idx, 2'b00} +: 4];
      add_cin = carry_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      last_grant <= 1'b1;
      id_reg     <= 1'b0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            a_reg      <= grant1 ? req1_a : req0_a;
            b_reg      <= grant1 ? req1_b : req0_b;
            carry_reg  <= grant1 ? req1_cin : req0_cin;
            id_reg     <= grant1;
            last_grant <= grant1;
            idx        <= '0;
            state      <= CALC;
          end
        end
        CALC: begin
          sum_reg[{idx, 2'b00} +: 4] <= add_sum;
          carry_reg <= add_cout;
          if (idx == LAST) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Response stays frozen until the consumer takes it.
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shared_adder_sched.sv
// Directed plus randomized bench for shared_adder_sched: a behavioural adder feeds the DUT,
// and expected sums, nibble drives and grant order come from plain arithmetic.
module tb_shared_adder_sched;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic [W-1:0] resp_sum;
  logic         resp_cout, resp_id, busy;

  int total  = 0;
  int passed = 0;
  int lg     = 1;

  shared_adder_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_id(resp_id),
    .busy(busy)
  );

  // The external combinational adder.
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Runs one full operation starting from a negedge in IDLE; ends on the negedge after
  // the response handshake.
  task automatic run_one(input int stall);
    int           w;
    longint       a, b, ci, res, msk, cin_k;
    if (req0_valid && req1_valid) w = 1 - lg;
    else w = req1_valid ? 1 : 0;
    a   = w ? req1_a : req0_a;
    b   = w ? req1_b : req0_b;
    ci  = w ? req1_cin : req0_cin;
    res = a + b + ci;
    #1;
    check("req0_ready_accept", req0_ready, w == 0);
    check("req1_ready_accept", req1_ready, w == 1);
    check("busy_idle", busy, 0);
    @(posedge clk);
    lg = w;
    for (int k = 0; k < NIB; k++) begin
      @(negedge clk);
      msk   = (64'd1 << (4 * k)) - 1;
      cin_k = (((a & msk) + (b & msk) + ci) >> (4 * k)) & 1;
      check("add_a_nib", add_a, (a >> (4 * k)) & 4'hF);
      check("add_b_nib", add_b, (b >> (4 * k)) & 4'hF);
      check("add_cin_nib", add_cin, cin_k);
      check("busy_calc", busy, 1);
      check("readies_calc", {req0_ready, req1_ready}, 0);
      check("resp_valid_calc", resp_valid, 0);
      if (k == NIB - 1 && stall > 0) resp_ready = 1'b0;
    end
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      check("resp_valid_done", resp_valid, 1);
      check("resp_sum", resp_sum, res & 64'hFFFF);
      check("resp_cout", resp_cout, (res >> W) & 1);
      check("resp_id", resp_id, w);
      check("readies_done", {req0_ready, req1_ready}, 0);
      check("add_drive_done", {add_a, add_b, add_cin}, 0);
      if (s == stall) resp_ready = 1'b1;
    end
    @(negedge clk);
    check("busy_after", busy, 0);
    check("resp_valid_after", resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    #1 rst_n = 1'b0;
    #12;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_sum", resp_sum, 0);
    check("rst_resp_cout", resp_cout, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_add", {add_a, add_b, add_cin}, 0);
    check("rst_readies", {req0_ready, req1_ready}, 0);

    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 1'b0;
    run_one(0);

    req0_a = 16'hFFFF; req0_b = 16'h0000; req0_cin = 1'b1;
    run_one(0);

    // Single req1 op so last grant is req1 before contention.
    req0_valid = 1'b0; req1_valid = 1'b1;
    req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
    run_one(0);

    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = W'($urandom); req0_b = W'($urandom);
    req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("contention_order", (lg == 1) ? 0 : 1, i % 2);
      run_one(0);
    end

    run_one(3);
    run_one(0);

    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(1, 3));
      req0_valid = r[0]; req1_valid = r[1];
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
      run_one(int'($urandom_range(0, 2)));
    end

    // Abort an operation mid-CALC.
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    lg = 1;
    check("abort_busy", busy, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_add", {add_a, add_b, add_cin}, 0);
    check("abort_sum", resp_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_no_resp", resp_valid, 0);
    req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 1'b0;
    run_one(0);
    run_one(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/shared_adder_sched.md
# shared_adder_sched

Sequencing controller that shares one external 4-bit ripple-carry adder between two requesters and performs WIDTH-bit additions one nibble per cycle. Each operation is accepted over a valid/ready handshake. The block drives the adder's operand and carry-in inputs, captures sum nibbles and the carry chain in registers, and returns the full result on a single response channel tagged with the requester ID. It sits between the requester logic and the existing combinational 4-bit adder, which is instantiated outside this block.

## Interface
- WIDTH, 16, operand/result width. Must be a multiple of 4 and at least 4. NIB = WIDTH/4.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_cin / req1_cin  in  1  initial carry-in.
- add_a, add_b  out  4  operand nibbles to the shared adder.
- add_cin  out  1  carry-in to the shared adder.
- add_sum  in  4  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  in  1  adder carry-out.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_sum  out  WIDTH  result.
- resp_cout  out  1  final carry-out.
- resp_id  out  1  requester that issued the operation (0 or 1).
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - Grant arbitration: if exactly one reqN_valid is high, that requester is granted. If both are high, the requester not in last_grant is granted.
  - reqN_ready = (state==IDLE) & grant_N. At most one ready is high in any cycle.
  - reqN_valid must not depend on reqN_ready.
  - On the accept cycle, latch a, b, cin and id into a_reg, b_reg, carry_reg and id_reg. Set idx=0, last_grant=id, then go to CALC.
- **CALC**
  - Adder drive: add_a = a_reg[4*idx +: 4], add_b = b_reg[4*idx +: 4], add_cin = carry_reg.
  - Each cycle: sum_reg[4*idx +: 4] <= add_sum, carry_reg <= add_cout, idx <= idx+1.
  - After the cycle with idx == NIB-1, go to DONE. idx is $clog2(NIB) bits wide, minimum 1 bit.
- **DONE**
  - resp_valid = 1; resp_sum = sum_reg, resp_cout = carry_reg, resp_id = id_reg. All response outputs are held stable while resp_ready is low.
  - On resp_valid & resp_ready, go to IDLE.
  - No request is accepted while in CALC or DONE.
- In IDLE and DONE, add_a, add_b and add_cin are driven to 0.
- Arithmetic: {resp_cout, resp_sum} = a + b + cin, modulo 2^(WIDTH+1). Inputs have no signed interpretation.

## Timing
- Reset values: state=IDLE, last_grant=1 (req0 wins the first contention), idx=0; all registers 0.
  - Outputs under reset: resp_valid=0, resp_sum=0, resp_cout=0, resp_id=0, busy=0, add_a=0, add_b=0, add_cin=0.
  - req0_ready and req1_ready are 0 unless the corresponding valid is high in IDLE.
- Latency: accept at edge T. The CALC cycles are T+1 .. T+NIB, and resp_valid rises at T+NIB+1.
- Minimum initiation interval is NIB+2 cycles: accept, NIB CALC cycles, one DONE cycle with resp_ready high, then the next accept in IDLE.
- Response backpressure stalls the block in DONE indefinitely. Requesters see ready=0 throughout the stall.
- Simultaneous events:
  - Both valids high in IDLE: round-robin selection as above.
  - A requester deasserting valid in IDLE: no effect unless it was the granted requester; grant is re-evaluated every cycle.
- Reset mid-operation: asynchronous clear to the reset values. The in-flight operation is discarded and no response is produced.
- NIB=1 (WIDTH=4): a single CALC cycle; resp_valid at T+2.

## Test plan
- Reset: hold rst_n low with req0_valid low. All outputs are 0 and busy=0. Release reset, raise req0_valid: req0_ready=1 in the same cycle.
- Single op, WIDTH=16: req0 a=0x1234, b=0x4321, cin=0, accepted at T. Expect add_a = 4,3,2,1 over T+1..T+4. Response at T+5: resp_sum=0x5555, resp_cout=0, resp_id=0.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1. Expect add_cin = 1,1,1,1 over the four CALC cycles. Result: resp_sum=0x0000, resp_cout=1.
- Contention: both valids held high, req1 a=0x8000, b=0x8000, cin=0. Expect grants in order 0,1,0,1. Each req1 response is resp_sum=0x0000, resp_cout=1, resp_id=1.
- Backpressure: resp_ready low for 3 cycles in DONE. resp_* stays stable and both readies stay 0. Raise resp_ready: handshake completes, the block is in IDLE the next cycle, and a pending request is accepted in that cycle.
- Reset in CALC: pulse rst_n low at idx=2. All outputs clear immediately and no resp_valid follows. With both valids high after release, req0 is granted first.
